// File: rtl/mac_carry_normalize.sv
// Carry normalizer behind the 27x27 MAC. It adds the running carry to each
// column sum, emits one limb per column and then flushes the residual carry.
module mac_carry_normalize #(
    parameter int limb_width = 27,
    parameter int i_width    = 64,
    parameter int idx_width  = 8
) (
    input  logic                  clk,
    input  logic                  aclr_n,
    input  logic [i_width-1:0]    col_data,
    input  logic                  col_valid,
    input  logic                  col_last,
    output logic                  col_ready,
    output logic [limb_width-1:0] limb_data,
    output logic [idx_width-1:0]  limb_idx,
    output logic                  limb_valid,
    output logic                  limb_last,
    input  logic                  limb_ready
);

    localparam int c_width     = i_width + 1 - limb_width;
    localparam int flush_limbs = (c_width + limb_width - 1) / limb_width;
    localparam int fc_width    = (flush_limbs > 1) ? $clog2(flush_limbs) : 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t               state;
    logic [c_width-1:0]   carry;
    logic [fc_width-1:0]  flush_cnt;
    logic [idx_width-1:0] next_idx;

    logic [i_width:0] acc;
    logic             out_free;
    logic             col_take;
    logic             flush_take;
    logic             flush_final;

    always_comb begin
        out_free    = ~limb_valid | limb_ready;
        col_take    = col_valid & col_ready;
        flush_take  = (state == FLUSH) & out_free;
        acc         = {1'b0, col_data} + (i_width+1)'(carry);
        flush_final = (flush_cnt == fc_width'(flush_limbs - 1));
    end

    // Held low during reset so nothing upstream sees a spurious accept.
    assign col_ready = aclr_n & (state == RUN) & out_free;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state      <= RUN;
            carry      <= '0;
            flush_cnt  <= '0;
            next_idx   <= '0;
            limb_data  <= '0;
            limb_idx   <= '0;
            limb_valid <= 1'b0;
            limb_last  <= 1'b0;
        end else begin
            if (col_take) begin
                limb_data  <= acc[limb_width-1:0];
                carry      <= acc[i_width:limb_width];
                limb_valid <= 1'b1;
                limb_last  <= 1'b0;
                limb_idx   <= next_idx;
                next_idx   <= next_idx + 1'b1;
                if (col_last) begin
                    state     <= FLUSH;
                    flush_cnt <= '0;
                end
            end else if (flush_take) begin
                limb_data  <= limb_width'(carry);
                carry      <= flush_final ? '0 : (carry >> limb_width);
                limb_valid <= 1'b1;
                limb_last  <= flush_final;
                limb_idx   <= next_idx;
                // The limb after a product's last limb restarts at index 0.
                next_idx   <= flush_final ? '0 : next_idx + 1'b1;
                flush_cnt  <= flush_cnt + 1'b1;
                if (flush_final)
                    state <= RUN;
            end else if (limb_ready) begin
                limb_valid <= 1'b0;
            end
        end
    end

endmodule
